// File: rtl/img_pkg.sv
// Shared definitions for the filtered-image RAM path.
//   arb_state_t : owner of the RAM slot in the next cycle
//   D_WIDTH_DEF : default pixel data width
//   A_WIDTH_DEF : default RAM address width (256x256 frame)
package img_pkg;

  localparam int unsigned D_WIDTH_DEF = 8;
  localparam int unsigned A_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_VGA,
    ARB_WR
  } arb_state_t;

endpackage

// File: rtl/wr_fifo.sv
// Synchronous write-back FIFO (no fall-through: an entry pushed in one cycle
// is visible at dout / counted as non-empty from the next cycle).
//   clk, rst : clock, asynchronous active-high reset
//   push     : write din (caller guarantees !full)
//   pop      : drop the head entry (caller guarantees !empty)
//   din/dout : entry in / head entry out
//   full, empty, level : occupancy status
module wr_fifo #(
  parameter  int unsigned WIDTH = 24,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned LW    = $clog2(DEPTH) + 1,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  assign dout  = mem[rptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // Storage itself needs no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= din;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/frame_ram_arbiter.sv
// Arbitrates one single-port synchronous image RAM (1-cycle read latency)
// between the VGA scan-out reader (high priority) and the median-filter
// write-back stream (buffered in wr_fifo). A starvation counter forces one
// write slot after STARVE_LIMIT consecutive VGA grants with writes pending.
//   CLK, RST                 : clock, asynchronous active-high reset
//   VGA_REQ/VGA_ADDR/VGA_GNT : read request, address, same-cycle grant
//   VGA_RVALID/VGA_RDATA     : read data returned two cycles after grant
//   WR_VALID/WR_ADDR/WR_DATA/WR_READY : write-back handshake into the FIFO
//   WR_IDLE                  : FIFO empty and no write on the RAM port
//   FIFO_LEVEL               : FIFO occupancy
//   RAM_ADDR/RAM_WREN/RAM_DATA/RAM_Q : registered RAM port, read data in
module frame_ram_arbiter
  import img_pkg::*;
#(
  parameter  int unsigned D_WIDTH      = D_WIDTH_DEF,
  parameter  int unsigned A_WIDTH      = A_WIDTH_DEF,
  parameter  int unsigned FIFO_DEPTH   = 4,
  parameter  int unsigned STARVE_LIMIT = 8,
  localparam int unsigned LW           = $clog2(FIFO_DEPTH) + 1,
  localparam int unsigned SW           = $clog2(STARVE_LIMIT + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               VGA_REQ,
  input  logic [A_WIDTH-1:0] VGA_ADDR,
  output logic               VGA_GNT,
  output logic               VGA_RVALID,
  output logic [D_WIDTH-1:0] VGA_RDATA,
  input  logic               WR_VALID,
  input  logic [A_WIDTH-1:0] WR_ADDR,
  input  logic [D_WIDTH-1:0] WR_DATA,
  output logic               WR_READY,
  output logic               WR_IDLE,
  output logic [LW-1:0]      FIFO_LEVEL,
  output logic [A_WIDTH-1:0] RAM_ADDR,
  output logic               RAM_WREN,
  output logic [D_WIDTH-1:0] RAM_DATA,
  input  logic [D_WIDTH-1:0] RAM_Q
);

  arb_state_t                 state_q;
  arb_state_t                 state_d;
  logic [SW-1:0]              cnt_q;
  logic [SW-1:0]              cnt_d;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;
  logic [A_WIDTH+D_WIDTH-1:0] head;
  logic [A_WIDTH-1:0]         head_addr;
  logic [D_WIDTH-1:0]         head_data;

  assign push = WR_VALID & ~fifo_full;
  assign {head_addr, head_data} = head;

  wr_fifo #(
    .WIDTH(A_WIDTH + D_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (CLK),
    .rst  (RST),
    .push (push),
    .pop  (pop),
    .din  ({WR_ADDR, WR_DATA}),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(FIFO_LEVEL)
  );

  assign WR_READY  = ~fifo_full;
  assign WR_IDLE   = fifo_empty & ~RAM_WREN;
  // RAM_Q already lines up with the read-valid pipe, so data passes straight through.
  assign VGA_RDATA = RAM_Q;

  always_comb begin
    state_d = ARB_IDLE;
    cnt_d   = cnt_q;
    VGA_GNT = 1'b0;
    pop     = 1'b0;
    if (!fifo_empty && cnt_q == SW'(STARVE_LIMIT)) begin
      state_d = ARB_WR;
      pop     = 1'b1;
      cnt_d   = '0;
    end else if (VGA_REQ) begin
      state_d = ARB_VGA;
      VGA_GNT = 1'b1;
      if (!fifo_empty && cnt_q != SW'(STARVE_LIMIT)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!fifo_empty) begin
      state_d = ARB_WR;
      pop     = 1'b1;
      cnt_d   = '0;
    end
  end

  // state_q names the current RAM slot owner, so a VGA slot now means read
  // data arrives next cycle; that doubles as the first read-valid stage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ARB_IDLE;
      cnt_q      <= '0;
      RAM_ADDR   <= '0;
      RAM_DATA   <= '0;
      RAM_WREN   <= 1'b0;
      VGA_RVALID <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      VGA_RVALID <= (state_q == ARB_VGA);
      RAM_WREN   <= (state_d == ARB_WR);
      case (state_d)
        ARB_VGA: RAM_ADDR <= VGA_ADDR;
        ARB_WR: begin
          RAM_ADDR <= head_addr;
          RAM_DATA <= head_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Self-checking bench for frame_ram_arbiter: directed scenarios plus random
// traffic, all checked each cycle against a queue-based reference model and a
// behavioural RAM.
module tb_frame_ram_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  localparam int LW    = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          VGA_REQ = 1'b0;
  logic [AW-1:0] VGA_ADDR = '0;
  logic          VGA_GNT;
  logic          VGA_RVALID;
  logic [DW-1:0] VGA_RDATA;
  logic          WR_VALID = 1'b0;
  logic [AW-1:0] WR_ADDR = '0;
  logic [DW-1:0] WR_DATA = '0;
  logic          WR_READY;
  logic          WR_IDLE;
  logic [LW-1:0] FIFO_LEVEL;
  logic [AW-1:0] RAM_ADDR;
  logic          RAM_WREN;
  logic [DW-1:0] RAM_DATA;
  logic [DW-1:0] RAM_Q = '0;

  always #5 CLK = ~CLK;

  frame_ram_arbiter #(
    .D_WIDTH(DW),
    .A_WIDTH(AW),
    .FIFO_DEPTH(DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .VGA_REQ(VGA_REQ), .VGA_ADDR(VGA_ADDR), .VGA_GNT(VGA_GNT),
    .VGA_RVALID(VGA_RVALID), .VGA_RDATA(VGA_RDATA),
    .WR_VALID(WR_VALID), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .WR_READY(WR_READY), .WR_IDLE(WR_IDLE), .FIFO_LEVEL(FIFO_LEVEL),
    .RAM_ADDR(RAM_ADDR), .RAM_WREN(RAM_WREN), .RAM_DATA(RAM_DATA),
    .RAM_Q(RAM_Q)
  );

  // Behavioural single-port RAM, read-before-write, 1-cycle read latency.
  logic [DW-1:0] ram [0:65535];
  always @(posedge CLK) begin
    if (RAM_WREN) ram[RAM_ADDR] <= RAM_DATA;
    RAM_Q <= ram[RAM_ADDR];
  end

  function automatic logic [DW-1:0] init_val(input int i);
    return 8'((i * 7 + 3) ^ (i >> 8));
  endfunction

  // Reference model state
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           wq[$];
  logic [DW-1:0] shadow [0:65535];
  int            scnt;
  bit            e_wren;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  bit            rd1_v;
  logic [AW-1:0] rd1_a;
  logic [DW-1:0] rd1_d;
  bit            e_rv;
  logic [DW-1:0] e_rd;

  logic [AW+DW-1:0] wlog[$];
  logic [DW-1:0]    rlog[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    scnt   = 0;
    e_wren = 0;
    e_addr = '0;
    e_data = '0;
    rd1_v  = 0;
    e_rv   = 0;
  endtask

  // One clock cycle: drive inputs, check every output, advance the model.
  task automatic step(input bit req, input logic [AW-1:0] va,
                      input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      output bit acc, output bit vg, output bit popped);
    int lvl;
    bit ne, dv, dw;
    wr_t e;
    VGA_REQ  = req;
    VGA_ADDR = va;
    WR_VALID = wv;
    WR_ADDR  = wa;
    WR_DATA  = wd;
    #1;
    lvl = wq.size();
    ne  = (lvl > 0);
    dw  = ne && (scnt == LIMIT);
    dv  = 0;
    if (!dw) begin
      if (req)     dv = 1;
      else if (ne) dw = 1;
    end
    chk("vga_gnt", 32'(VGA_GNT), 32'(dv));
    chk("wr_ready", 32'(WR_READY), 32'(lvl != DEPTH));
    chk("fifo_level", 32'(FIFO_LEVEL), 32'(lvl));
    chk("wr_idle", 32'(WR_IDLE), 32'((lvl == 0) && !e_wren));
    chk("ram_wren", 32'(RAM_WREN), 32'(e_wren));
    if (e_wren) begin
      chk("ram_waddr", 32'(RAM_ADDR), 32'(e_addr));
      chk("ram_wdata", 32'(RAM_DATA), 32'(e_data));
    end
    if (RAM_WREN) wlog.push_back({RAM_ADDR, RAM_DATA});
    if (rd1_v) chk("ram_raddr", 32'(RAM_ADDR), 32'(rd1_a));
    chk("vga_rvalid", 32'(VGA_RVALID), 32'(e_rv));
    if (e_rv) chk("vga_rdata", 32'(VGA_RDATA), 32'(e_rd));
    if (VGA_RVALID) rlog.push_back(VGA_RDATA);
    // The write occupying this slot lands in RAM at the coming edge.
    if (e_wren) shadow[e_addr] = e_data;
    e_rv  = rd1_v;
    e_rd  = rd1_d;
    rd1_v = dv;
    rd1_a = va;
    rd1_d = shadow[va];
    if (dw) begin
      e      = wq.pop_front();
      e_wren = 1;
      e_addr = e.a;
      e_data = e.d;
      scnt   = 0;
    end else begin
      e_wren = 0;
    end
    if (dv && ne && scnt < LIMIT) scnt++;
    acc = wv && (lvl < DEPTH);
    if (acc) wq.push_back('{a: wa, d: wd});
    vg     = dv;
    popped = dw;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    VGA_REQ  = 0;
    WR_VALID = 0;
    RST      = 1;
    #1;
    chk("rst_rvalid", 32'(VGA_RVALID), 32'd0);
    chk("rst_wren", 32'(RAM_WREN), 32'd0);
    chk("rst_level", 32'(FIFO_LEVEL), 32'd0);
    chk("rst_ready", 32'(WR_READY), 32'd1);
    chk("rst_idle", 32'(WR_IDLE), 32'd1);
    chk("rst_addr", 32'(RAM_ADDR), 32'd0);
    chk("rst_data", 32'(RAM_DATA), 32'd0);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RST = 0;
  endtask

  initial begin
    bit acc, vg, pp;
    int run, accepted, full_seen, pp_seen;
    logic [LW-1:0] lv [6];
    logic [AW+DW-1:0] exp_w [3];

    for (int i = 0; i < 65536; i++) begin
      ram[i]    = init_val(i);
      shadow[i] = init_val(i);
    end
    model_reset();
    @(negedge CLK);
    do_reset();

    // 1: back-to-back reads of addresses 0..15, FIFO empty
    rlog.delete();
    for (int i = 0; i < 18; i++)
      step(i < 16, AW'(i < 16 ? i : 0), 0, '0, '0, acc, vg, pp);
    chk("t1_nreads", 32'(rlog.size()), 32'd16);
    for (int i = 0; i < 16 && i < rlog.size(); i++)
      chk("t1_rdata", 32'(rlog[i]), 32'(init_val(i)));

    // 2: three writes, no VGA traffic
    wlog.delete();
    step(0, '0, 1, 16'h0101, 8'hAA, acc, vg, pp);
    step(0, '0, 1, 16'h0102, 8'hBB, acc, vg, pp);
    step(0, '0, 1, 16'h0103, 8'hCC, acc, vg, pp);
    for (int i = 0; i < 4; i++) step(0, '0, 0, '0, '0, acc, vg, pp);
    exp_w[0] = {16'h0101, 8'hAA};
    exp_w[1] = {16'h0102, 8'hBB};
    exp_w[2] = {16'h0103, 8'hCC};
    chk("t2_nwrites", 32'(wlog.size()), 32'd3);
    for (int i = 0; i < 3 && i < wlog.size(); i++)
      chk("t2_write", 32'(wlog[i]), 32'(exp_w[i]));
    chk("t2_idle", 32'(WR_IDLE), 32'd1);
    // Read one back through the arbiter
    for (int i = 0; i < 3; i++) step(i == 0, 16'h0102, 0, '0, '0, acc, vg, pp);
    chk("t2_readback", 32'(rlog[rlog.size()-1]), 32'hBB);

    // 3: VGA held high, one write; twice to show the counter restarts at 0
    for (int k = 0; k < 2; k++) begin
      step(1, AW'(k), 1, AW'(16'h0300 + k), 8'(8'h30 + k), acc, vg, pp);
      run = 0;
      for (int i = 0; i < 20; i++) begin
        step(1, AW'(i), 0, '0, '0, acc, vg, pp);
        if (!vg) break;
        run++;
      end
      chk("t3_grant_run", 32'(run), 32'd8);
      step(1, '0, 0, '0, '0, acc, vg, pp);
      chk("t3_idle_after", 32'(WR_IDLE), 32'd1);
    end

    // 4: five writes offered back-to-back while VGA saturates the port
    accepted  = 0;
    full_seen = 0;
    for (int i = 0; i < 40 && accepted < 5; i++) begin
      if (FIFO_LEVEL == LW'(DEPTH) && !WR_READY) full_seen = 1;
      step(1, AW'(i), 1, AW'(16'h0400 + accepted), 8'(8'h40 + accepted), acc, vg, pp);
      if (acc) accepted++;
    end
    chk("t4_accepted", 32'(accepted), 32'd5);
    chk("t4_full_seen", 32'(full_seen), 32'd1);
    // Drain with a producer that keeps pushing: push and pop coincide
    pp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      lv[i] = FIFO_LEVEL;
      step(0, '0, 1, AW'(16'h0500 + i), 8'(8'h50 + i), acc, vg, pp);
      if (acc && pp) pp_seen = 1;
    end
    chk("t4_pushpop_seen", 32'(pp_seen), 32'd1);
    for (int i = 2; i < 6; i++) chk("t4_level_const", 32'(lv[i]), 32'(lv[1]));
    for (int i = 0; i < 8; i++) step(0, '0, 0, '0, '0, acc, vg, pp);
    chk("t4_idle", 32'(WR_IDLE), 32'd1);

    // 5: reset with three queued writes and a read in flight
    do_reset();
    for (int i = 0; i < 3; i++)
      step(1, AW'(i), 1, AW'(16'h0200 + i), 8'hEE, acc, vg, pp);
    chk("t5_level3", 32'(FIFO_LEVEL), 32'd3);
    step(1, 16'h0007, 0, '0, '0, acc, vg, pp);
    do_reset();
    chk("t5_level_after", 32'(FIFO_LEVEL), 32'd0);
    chk("t5_rvalid_after", 32'(VGA_RVALID), 32'd0);
    wlog.delete();
    for (int i = 0; i < 12; i++) step(i < 3, AW'(16'h0200 + i), 0, '0, '0, acc, vg, pp);
    chk("t5_no_stale_write", 32'(wlog.size()), 32'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 9) < 7, AW'($urandom_range(0, 63)),
           $urandom_range(0, 1) == 1, AW'($urandom_range(0, 63)), DW'($urandom),
           acc, vg, pp);
    end
    for (int i = 0; i < 20; i++) step(0, '0, 0, '0, '0, acc, vg, pp);
    chk("final_idle", 32'(WR_IDLE), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
